// File: rtl/ahb2apb_bridge_mc_if.sv
// AHB-Lite slave port and APB3 master port of ahb2apb_bridge_mc, grouped as one bundle.
// slave = bridge view, master = view of the surrounding AHB master and APB cluster.
interface ahb2apb_bridge_mc_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                  HSEL;
    logic [ADDR_W-1:0]     HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [DATA_W-1:0]     HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_W-1:0]     HRDATA;
    logic [ADDR_W-1:0]     PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    logic                  post_err;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA, post_err
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA, post_err
    );
endinterface

// File: rtl/ahb2apb_bridge_mc.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLAVES one-hot selects, PREADY waits and PSLVERR->ERROR.
// Optional write posting is enabled by defining AHB2APB_WRITE_POSTING_EN.
module ahb2apb_bridge_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12
) (
    input logic                clk,
    input logic                rst,
    ahb2apb_bridge_mc_if.slave bus
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [IDX_W:0] NUM_MAPPED = (IDX_W + 1)'(NUM_SLAVES);

`ifdef AHB2APB_WRITE_POSTING_EN
    localparam bit POST_EN = 1'b1;
`else
    localparam bit POST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, CAPT, SETUP, ACCESS, DONE, ERR1, ERR2
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] cur_addr, pend_addr;
    logic              cur_write, pend_write, pend_valid, posted;
    logic [DATA_W-1:0] pwdata_q, hrdata_q;
    logic [IDX_W-1:0]  cur_idx;
    logic              accept, mapped, finish;
    logic              take_bus, take_pend, hold_pend;
    logic              latch_wdata, latch_rdata;
    logic              ready, resp, penable, apb_sel;

    assign accept  = bus.HSEL && bus.HREADY && (bus.HTRANS inside {2'b10, 2'b11});
    assign cur_idx = cur_addr[SEL_LSB +: IDX_W];
    assign mapped  = ({1'b0, cur_idx} < NUM_MAPPED);

    // Posted writes run SETUP/ACCESS in the background; a transfer taken meanwhile
    // parks in the pending slot and is started once the background cycle finishes.
    always_comb begin
        state_d     = state;
        ready       = 1'b1;
        resp        = 1'b0;
        penable     = 1'b0;
        apb_sel     = 1'b0;
        take_bus    = 1'b0;
        take_pend   = 1'b0;
        hold_pend   = 1'b0;
        latch_wdata = 1'b0;
        latch_rdata = 1'b0;
        finish      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    take_bus = 1'b1;
                    state_d  = CAPT;
                end
            end
            CAPT: begin
                latch_wdata = cur_write;
                if (posted) begin
                    if (mapped) begin
                        state_d   = SETUP;
                        hold_pend = accept;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    ready   = 1'b0;
                    state_d = mapped ? SETUP : ERR1;
                end
            end
            SETUP: begin
                ready     = posted && !pend_valid;
                apb_sel   = 1'b1;
                hold_pend = posted && accept;
                state_d   = ACCESS;
            end
            ACCESS: begin
                ready   = posted && !pend_valid;
                apb_sel = 1'b1;
                penable = 1'b1;
                if (bus.PREADY) begin
                    if (posted) begin
                        finish = 1'b1;
                    end else if (bus.PSLVERR) begin
                        state_d = ERR1;
                    end else begin
                        latch_rdata = !cur_write;
                        state_d     = DONE;
                    end
                end else begin
                    hold_pend = posted && accept;
                end
            end
            DONE, ERR2: begin
                resp = (state == ERR2);
                if (accept) begin
                    take_bus = 1'b1;
                    state_d  = CAPT;
                end else begin
                    state_d = IDLE;
                end
            end
            ERR1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = ERR2;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            if (pend_valid) begin
                take_pend = 1'b1;
                state_d   = CAPT;
            end else if (accept) begin
                take_bus = 1'b1;
                state_d  = CAPT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            cur_write  <= 1'b0;
            posted     <= 1'b0;
            pend_addr  <= '0;
            pend_write <= 1'b0;
            pend_valid <= 1'b0;
            pwdata_q   <= '0;
            hrdata_q   <= '0;
        end else begin
            state <= state_d;
            if (take_bus) begin
                cur_addr  <= bus.HADDR;
                cur_write <= bus.HWRITE;
                posted    <= POST_EN && bus.HWRITE;
            end else if (take_pend) begin
                cur_addr  <= pend_addr;
                cur_write <= pend_write;
                posted    <= pend_write;
            end
            if (take_pend) begin
                pend_valid <= 1'b0;
            end else if (hold_pend && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.HADDR;
                pend_write <= bus.HWRITE;
            end
            if (latch_wdata) begin
                pwdata_q <= bus.HWDATA;
            end
            if (latch_rdata) begin
                hrdata_q <= bus.PRDATA;
            end
        end
    end

`ifdef AHB2APB_WRITE_POSTING_EN
    logic post_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_err_q <= 1'b0;
        end else if ((state == ACCESS && posted && bus.PREADY && bus.PSLVERR) ||
                     (state == CAPT && posted && !mapped)) begin
            post_err_q <= 1'b1;
        end
    end

    assign bus.post_err = post_err_q;
`else
    assign bus.post_err = 1'b0;
`endif

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = cur_addr;
    assign bus.PWRITE    = cur_write;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PENABLE   = penable;
    assign bus.PSEL      = apb_sel ? (NUM_SLAVES'(1) << cur_idx) : '0;
endmodule
